// File: rtl/gsu_opcodes.sv
// gsu_opcodes: shared constants for the GSU prefix/register-select logic.
// Provides opcode range bases, the ALT prefix opcodes, widths and the
// op_kind encoding carried by each decode record.
package gsu_opcodes;

  localparam int OPCODE_WIDTH = 8;
  localparam int SELECT_WIDTH = 4;

  // Range bases; the low nibble of the opcode is the register number.
  localparam logic [OPCODE_WIDTH-1:0] WITH_BASE = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] TO_BASE   = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] FROM_BASE = 8'hB0;
  localparam logic [OPCODE_WIDTH-1:0] RANGE_MASK = 8'hF0;

  localparam logic [OPCODE_WIDTH-1:0] ALT1 = 8'h3D;
  localparam logic [OPCODE_WIDTH-1:0] ALT2 = 8'h3E;
  localparam logic [OPCODE_WIDTH-1:0] ALT3 = 8'h3F;

  typedef enum logic [1:0] {
    KIND_EXEC  = 2'd0,
    KIND_MOVE  = 2'd1,
    KIND_MOVES = 2'd2
  } op_kind_e;

endpackage

// File: rtl/prefix_decoder.sv
// prefix_decoder: combinational classification of one opcode.
// Ports:
//   opcode_i     - opcode being accepted
//   b_flag_i     - WITH prefix seen (turns TO/FROM into MOVE/MOVES)
//   is_prefix_o  - opcode only updates prefix state, no record
//   kind_o       - record kind when not a prefix
//   wr_sreg_o    - load sreg from opcode[3:0]
//   wr_dreg_o    - load dreg from opcode[3:0]
//   set_b_o      - set b_flag
//   wr_alt_o     - load {alt2,alt1} from alt_val_o
//   alt_val_o    - new {alt2,alt1}
//   src_from_n_o - record source comes from opcode[3:0] instead of sreg
//   dst_from_n_o - record destination comes from opcode[3:0] instead of dreg
module prefix_decoder
  import gsu_opcodes::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    b_flag_i,
  output logic                    is_prefix_o,
  output op_kind_e                kind_o,
  output logic                    wr_sreg_o,
  output logic                    wr_dreg_o,
  output logic                    set_b_o,
  output logic                    wr_alt_o,
  output logic [1:0]              alt_val_o,
  output logic                    src_from_n_o,
  output logic                    dst_from_n_o
);

  logic [OPCODE_WIDTH-1:0] range_bits;
  assign range_bits = opcode_i & RANGE_MASK;

  always_comb begin
    is_prefix_o  = 1'b0;
    kind_o       = KIND_EXEC;
    wr_sreg_o    = 1'b0;
    wr_dreg_o    = 1'b0;
    set_b_o      = 1'b0;
    wr_alt_o     = 1'b0;
    alt_val_o    = 2'b00;
    src_from_n_o = 1'b0;
    dst_from_n_o = 1'b0;

    if (range_bits == WITH_BASE) begin
      is_prefix_o = 1'b1;
      wr_sreg_o   = 1'b1;
      wr_dreg_o   = 1'b1;
      set_b_o     = 1'b1;
    end else if (range_bits == TO_BASE) begin
      if (b_flag_i) begin
        kind_o       = KIND_MOVE;
        dst_from_n_o = 1'b1;
      end else begin
        is_prefix_o = 1'b1;
        wr_dreg_o   = 1'b1;
      end
    end else if (range_bits == FROM_BASE) begin
      if (b_flag_i) begin
        kind_o       = KIND_MOVES;
        src_from_n_o = 1'b1;
      end else begin
        is_prefix_o = 1'b1;
        wr_sreg_o   = 1'b1;
      end
    end else if (opcode_i == ALT1) begin
      is_prefix_o = 1'b1;
      wr_alt_o    = 1'b1;
      alt_val_o   = 2'b01;
    end else if (opcode_i == ALT2) begin
      is_prefix_o = 1'b1;
      wr_alt_o    = 1'b1;
      alt_val_o   = 2'b10;
    end else if (opcode_i == ALT3) begin
      is_prefix_o = 1'b1;
      wr_alt_o    = 1'b1;
      alt_val_o   = 2'b11;
    end
  end

endmodule

// File: rtl/register_select_sequencer.sv
// register_select_sequencer: absorbs GSU prefix opcodes (WITH/TO/FROM/ALTx)
// and emits one registered decode record per executing instruction, carrying
// the source/destination register selectors for the register-file read muxes.
// Ports:
//   clock, reset     - clock; synchronous active-high reset
//   flush            - drops prefix state, the output record and the
//                      opcode presented this cycle
//   opcode, opcode_valid / opcode_ready  - input stream
//   execute_ready    - downstream consumes the current record
//   op_valid, op_code, source_select, dest_select, alt_mode, op_kind
//                    - registered decode record
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. opcode_ready = !op_valid || execute_ready, so the record is held
// stable while op_valid && !execute_ready and the input stream stalls.
module register_select_sequencer
  import gsu_opcodes::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    opcode_valid,
  output logic                    opcode_ready,
  input  logic                    execute_ready,
  output logic                    op_valid,
  output logic [OPCODE_WIDTH-1:0] op_code,
  output logic [SELECT_WIDTH-1:0] source_select,
  output logic [SELECT_WIDTH-1:0] dest_select,
  output logic [1:0]              alt_mode,
  output logic [1:0]              op_kind
);

  // Prefix state
  logic [SELECT_WIDTH-1:0] sreg_q, sreg_d;
  logic [SELECT_WIDTH-1:0] dreg_q, dreg_d;
  logic                    b_flag_q, b_flag_d;
  logic [1:0]              alt_q, alt_d;     // {alt2, alt1}

  // Output record
  logic                    valid_q, valid_d;
  logic [OPCODE_WIDTH-1:0] code_q, code_d;
  logic [SELECT_WIDTH-1:0] src_q, src_d;
  logic [SELECT_WIDTH-1:0] dst_q, dst_d;
  logic [1:0]              rec_alt_q, rec_alt_d;
  op_kind_e                kind_q, kind_d;

  // Decoder outputs
  logic                    dec_is_prefix;
  op_kind_e                dec_kind;
  logic                    dec_wr_sreg, dec_wr_dreg, dec_set_b, dec_wr_alt;
  logic [1:0]              dec_alt_val;
  logic                    dec_src_from_n, dec_dst_from_n;

  logic                    accept;
  logic [SELECT_WIDTH-1:0] n;

  assign n            = opcode[SELECT_WIDTH-1:0];
  assign opcode_ready = !valid_q || execute_ready;
  assign accept       = opcode_valid && opcode_ready;

  prefix_decoder u_prefix_decoder (
    .opcode_i     (opcode),
    .b_flag_i     (b_flag_q),
    .is_prefix_o  (dec_is_prefix),
    .kind_o       (dec_kind),
    .wr_sreg_o    (dec_wr_sreg),
    .wr_dreg_o    (dec_wr_dreg),
    .set_b_o      (dec_set_b),
    .wr_alt_o     (dec_wr_alt),
    .alt_val_o    (dec_alt_val),
    .src_from_n_o (dec_src_from_n),
    .dst_from_n_o (dec_dst_from_n)
  );

  always_comb begin
    sreg_d    = sreg_q;
    dreg_d    = dreg_q;
    b_flag_d  = b_flag_q;
    alt_d     = alt_q;
    valid_d   = valid_q;
    code_d    = code_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rec_alt_d = rec_alt_q;
    kind_d    = kind_q;

    // Record consumed; a new record below re-asserts valid.
    if (valid_q && execute_ready) begin
      valid_d = 1'b0;
    end

    if (flush) begin
      valid_d  = 1'b0;
      sreg_d   = '0;
      dreg_d   = '0;
      b_flag_d = 1'b0;
      alt_d    = 2'b00;
    end else if (accept) begin
      if (dec_is_prefix) begin
        if (dec_wr_sreg) sreg_d = n;
        if (dec_wr_dreg) dreg_d = n;
        if (dec_set_b)   b_flag_d = 1'b1;
        if (dec_wr_alt)  alt_d = dec_alt_val;
      end else begin
        valid_d   = 1'b1;
        code_d    = opcode;
        src_d     = dec_src_from_n ? n : sreg_q;
        dst_d     = dec_dst_from_n ? n : dreg_q;
        rec_alt_d = alt_q;
        kind_d    = dec_kind;
        // Every executing instruction ends the prefix chain.
        sreg_d    = '0;
        dreg_d    = '0;
        b_flag_d  = 1'b0;
        alt_d     = 2'b00;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg_q    <= '0;
      dreg_q    <= '0;
      b_flag_q  <= 1'b0;
      alt_q     <= 2'b00;
      valid_q   <= 1'b0;
      code_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rec_alt_q <= 2'b00;
      kind_q    <= KIND_EXEC;
    end else begin
      sreg_q    <= sreg_d;
      dreg_q    <= dreg_d;
      b_flag_q  <= b_flag_d;
      alt_q     <= alt_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rec_alt_q <= rec_alt_d;
      kind_q    <= kind_d;
    end
  end

  assign op_valid      = valid_q;
  assign op_code       = code_q;
  assign source_select = src_q;
  assign dest_select   = dst_q;
  assign alt_mode      = rec_alt_q;
  assign op_kind       = kind_q;

endmodule

// File: tb/tb_register_select_sequencer.sv
// Bench for register_select_sequencer: directed scenarios followed by random
// traffic, all checked against a prefix-state model with an expected-record
// queue.
module tb_register_select_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] opcode;
  logic       opcode_valid;
  logic       opcode_ready;
  logic       execute_ready;
  logic       op_valid;
  logic [7:0] op_code;
  logic [3:0] source_select;
  logic [3:0] dest_select;
  logic [1:0] alt_mode;
  logic [1:0] op_kind;

  int checks = 0;
  int errors = 0;

  // Record layout: {op_code[7:0], src[3:0], dst[3:0], alt[1:0], kind[1:0]}
  localparam int RW = 20;
  logic [RW-1:0] exp_q[$];

  // Model prefix state
  int m_s, m_d, m_b, m_a1, m_a2;

  always #5 clock = ~clock;

  register_select_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .opcode        (opcode),
    .opcode_valid  (opcode_valid),
    .opcode_ready  (opcode_ready),
    .execute_ready (execute_ready),
    .op_valid      (op_valid),
    .op_code       (op_code),
    .source_select (source_select),
    .dest_select   (dest_select),
    .alt_mode      (alt_mode),
    .op_kind       (op_kind)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_s = 0; m_d = 0; m_b = 0; m_a1 = 0; m_a2 = 0;
  endfunction

  function automatic void model_push(input int op, input int src, input int dst, input int kind);
    logic [RW-1:0] r;
    r = {op[7:0], src[3:0], dst[3:0], m_a2[0], m_a1[0], kind[1:0]};
    exp_q.push_back(r);
    model_clear();
  endfunction

  // Apply one opcode to the model using the opcode-range rules.
  function automatic void model_accept(input int op);
    int hi, n;
    hi = op / 16;
    n  = op % 16;
    if (hi == 2) begin
      m_s = n; m_d = n; m_b = 1;
    end else if (hi == 1 && m_b == 0) begin
      m_d = n;
    end else if (hi == 1) begin
      model_push(op, m_s, n, 1);
    end else if (hi == 11 && m_b == 0) begin
      m_s = n;
    end else if (hi == 11) begin
      model_push(op, n, m_d, 2);
    end else if (op == 'h3D) begin
      m_a1 = 1; m_a2 = 0;
    end else if (op == 'h3E) begin
      m_a1 = 0; m_a2 = 1;
    end else if (op == 'h3F) begin
      m_a1 = 1; m_a2 = 1;
    end else begin
      model_push(op, m_s, m_d, 0);
    end
  endfunction

  // One clock cycle: drive, check current outputs, advance model, clock.
  task automatic cycle(input logic v, input logic [7:0] op, input logic er,
                       input logic fl, input logic rs);
    logic [RW-1:0] r;
    bit            ready;
    opcode_valid  = v;
    opcode        = op;
    execute_ready = er;
    flush         = fl;
    reset         = rs;
    @(negedge clock);
    check("op_valid", op_valid, exp_q.size() != 0);
    ready = (exp_q.size() == 0) || er;
    check("opcode_ready", opcode_ready, ready);
    if (exp_q.size() != 0) begin
      r = exp_q[0];
      check("op_code", op_code, r[19:12]);
      check("source_select", source_select, r[11:8]);
      check("dest_select", dest_select, r[7:4]);
      check("alt_mode", alt_mode, r[3:2]);
      check("op_kind", op_kind, r[1:0]);
    end
    if (rs) begin
      exp_q.delete();
      model_clear();
    end else begin
      if (exp_q.size() != 0 && er) void'(exp_q.pop_front());
      if (fl) begin
        exp_q.delete();
        model_clear();
      end else if (v && ready) begin
        model_accept(int'(op));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] op);
    cycle(1'b1, op, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int rnd_op;
    reset = 1'b1; flush = 1'b0; opcode = 8'h00; opcode_valid = 1'b0; execute_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", op_valid, 1'b0);
    check("rst_code", op_code, 8'h00);
    check("rst_src", source_select, 4'd0);
    check("rst_dst", dest_select, 4'd0);
    check("rst_alt", alt_mode, 2'd0);
    check("rst_kind", op_kind, 2'd0);
    reset = 1'b0;

    // 1: WITH R10 then exec
    send(8'h2A);
    check("t1_no_rec", op_valid, 1'b0);
    send(8'h50);
    check("t1_valid", op_valid, 1'b1);
    check("t1_src", source_select, 4'd10);
    check("t1_dst", dest_select, 4'd10);
    check("t1_kind", op_kind, 2'd0);
    send(8'h51);
    check("t1_clear_src", source_select, 4'd0);
    idle();

    // 2: FROM R3, TO R5, ALT1, exec
    send(8'hB3); send(8'h15); send(8'h3D);
    check("t2_no_rec", op_valid, 1'b0);
    send(8'h60);
    check("t2_src", source_select, 4'd3);
    check("t2_dst", dest_select, 4'd5);
    check("t2_alt", alt_mode, 2'b01);
    idle();

    // 3: MOVE and MOVES
    send(8'h27); send(8'h1C);
    check("t3_move_kind", op_kind, 2'd1);
    check("t3_move_src", source_select, 4'd7);
    check("t3_move_dst", dest_select, 4'd12);
    send(8'h24); send(8'hB9);
    check("t3_moves_kind", op_kind, 2'd2);
    check("t3_moves_src", source_select, 4'd9);
    check("t3_moves_dst", dest_select, 4'd4);
    idle();

    // 4: backpressure
    cycle(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cycle(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
      check("t4_hold", op_code, 8'h50);
    end
    cycle(1'b1, 8'h51, 1'b1, 1'b0, 1'b0);
    check("t4_next", op_code, 8'h51);
    idle();

    // 5: flush drops prefix and opcode
    send(8'h2E);
    cycle(1'b1, 8'h70, 1'b1, 1'b1, 1'b0);
    check("t5_dropped", op_valid, 1'b0);
    send(8'h71);
    check("t5_src", source_select, 4'd0);
    check("t5_dst", dest_select, 4'd0);
    idle();

    // 6: ALT chain, then reset mid-chain
    send(8'h3F); send(8'h3E); send(8'h40);
    check("t6_alt", alt_mode, 2'b10);
    idle();
    send(8'hB5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h42);
    check("t6_rst_src", source_select, 4'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0: rnd_op = 'h20 + $urandom_range(0, 15);
        1: rnd_op = 'h10 + $urandom_range(0, 15);
        2: rnd_op = 'hB0 + $urandom_range(0, 15);
        3: rnd_op = 'h3D + $urandom_range(0, 2);
        default: rnd_op = $urandom_range(0, 255);
      endcase
      cycle($urandom_range(0, 3) != 0, rnd_op[7:0], $urandom_range(0, 3) != 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 250) == 0);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_select_sequencer.md
Name: register_select_sequencer

Overview:
- Opcode-stream stage that tracks GSU prefix state: FROM/TO/WITH register pointers, ALT1/ALT2 and the B flag.
- Consumes prefix opcodes and emits one registered decode record per executing instruction.
- The record carries the 4-bit source and destination register selectors.
- Sits directly upstream of the register-file read muxes (mux_2_bit_4_wide trees); its source_select and dest_select drive their selector inputs.

Parameters:
- OPCODE_WIDTH, 8, opcode width; fixed, not overridable.
- SELECT_WIDTH, 4, register selector width (R0..R15); fixed.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards prefix state and the output record (branch taken / GO cleared).
- opcode  input  8  fetched opcode.
- opcode_valid  input  1  opcode is present.
- opcode_ready  output  1  sequencer accepts opcode this cycle.
- execute_ready  input  1  downstream consumes the output record.
- op_valid  output  1  decode record valid.
- op_code  output  8  opcode of the record.
- source_select  output  4  Sreg for the record.
- dest_select  output  4  Dreg for the record.
- alt_mode  output  2  {ALT2,ALT1} in effect for the record.
- op_kind  output  2  0=EXEC, 1=MOVE, 2=MOVES.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Internal state: sreg[3:0], dreg[3:0], b_flag, alt1, alt2.
- Reset: sreg=dreg=0, b_flag=alt1=alt2=0, op_valid=0, op_code=0, source_select=0, dest_select=0, alt_mode=0, op_kind=0.
- Handshake: opcode_ready = !op_valid || execute_ready (combinational). Accept = opcode_valid && opcode_ready.
- Output record holds stable while op_valid && !execute_ready.
- If op_valid && execute_ready and nothing new is produced, op_valid clears next cycle.
- Decode on accept (n = opcode[3:0]):
  - 0x20-0x2F WITH: prefix. sreg=dreg=n, b_flag=1. ALT bits unchanged. No record.
  - 0x10-0x1F with b_flag=0, TO: prefix. dreg=n. No record.
  - 0x10-0x1F with b_flag=1, MOVE: record op_kind=MOVE, source_select=sreg, dest_select=n.
  - 0xB0-0xBF with b_flag=0, FROM: prefix. sreg=n. No record.
  - 0xB0-0xBF with b_flag=1, MOVES: record op_kind=MOVES, source_select=n, dest_select=dreg.
  - 0x3D ALT1: alt1=1, alt2=0. 0x3E ALT2: alt1=0, alt2=1. 0x3F ALT3: alt1=1, alt2=1. All prefixes, no record. sreg/dreg/b unchanged.
  - All other opcodes: record op_kind=EXEC, source_select=sreg, dest_select=dreg, alt_mode={alt2,alt1}.
- After any record-producing accept, next state is sreg=dreg=0, b_flag=alt1=alt2=0.
- Latency: record appears one cycle after accept. Prefixes are absorbed with zero output cycles. Back-to-back accepts give one record per cycle.
- Prefix accept while op_valid && execute_ready: op_valid falls next cycle; prefix state updates in the same edge.
- Prefix chains of any length: last writer wins per field; a WITH after a TO overrides dreg.
- flush has priority over accept: op_valid=0, prefix state cleared, the opcode presented that cycle is dropped. opcode_ready is unaffected by flush.
- Reset mid-chain: all prefix state lost, identical to the reset values.
- alt_mode, op_code and op_kind are registered alongside op_valid and are don't-care when op_valid=0; they hold their last value.

Decomposition:
- Shared package gsu_opcodes:
  - opcode range constants: WITH_BASE=0x20, TO_BASE=0x10, FROM_BASE=0xB0, ALT1=0x3D, ALT2=0x3E, ALT3=0x3F.
  - op_kind encodings.
  - SELECT_WIDTH.
- One natural sub-module: prefix_decoder, combinational. Maps opcode and b_flag to {is_prefix, kind, field writes}.
- The top block holds state, handshake and the output register.

Test Plan:
1. Reset, then 0x2A (WITH R10), then 0x50 -> one record: op_code=0x50, source_select=10, dest_select=10, op_kind=EXEC, alt_mode=0; then state back to R0/R0.
2. 0xB3 (FROM R3), 0x15 (TO R5), 0x3D (ALT1), 0x60 -> one record: source_select=3, dest_select=5, alt_mode=01; no records for the three prefixes.
3. 0x27 (WITH R7), 0x1C -> MOVE record: source_select=7, dest_select=12. Then 0x24 (WITH R4), 0xB9 -> MOVES record: source_select=9, dest_select=4.
4. Backpressure: execute_ready=0 for 3 cycles with 0x50 then 0x51 offered -> opcode_ready=0 and the record holds 0x50 unchanged. When execute_ready=1, 0x51 is accepted and its record follows next cycle.
5. 0x2E (WITH R14), then flush asserted together with opcode_valid on 0x70 -> op_valid stays 0 and 0x70 is dropped. A following 0x71 produces a record with source_select=dest_select=0.
6. 0x3F (ALT3), 0x3E (ALT2), 0x40 -> alt_mode=10. Reset asserted mid-chain after 0xB5 -> next exec record has source_select=0.
